// File: rtl/xillybus_mem_regfile.sv
// Addressable DEPTH x DATA_W register file behind the xillybus seekable mem stream pair, plus a fabric port.
// Host read and fabric read have 1-cycle latency; full/empty/eof come from past_end, so they only rise when WRAP=0.
module xillybus_mem_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int WRAP   = 1
) (
  input  logic              bus_clk_w,
  input  logic              bus_rst_n_w,
  input  logic [ADDR_W-1:0] user_mem_addr_w,
  input  logic              user_mem_addr_update_w,
  input  logic [DATA_W-1:0] user_w_mem_data_w,
  input  logic              user_w_mem_wren_w,
  input  logic              user_w_mem_open_w,
  output logic              user_w_mem_full_w,
  input  logic              user_r_mem_rden_w,
  input  logic              user_r_mem_open_w,
  output logic [DATA_W-1:0] user_r_mem_data_w,
  output logic              user_r_mem_empty_w,
  output logic              user_r_mem_eof_w,
  input  logic [ADDR_W-1:0] fab_addr_w,
  input  logic              fab_wr_en_w,
  input  logic [DATA_W-1:0] fab_wr_data_w,
  output logic [DATA_W-1:0] fab_rd_data_w,
  output logic              host_wr_valid_w,
  output logic [ADDR_W-1:0] host_wr_addr_w,
  output logic [DATA_W-1:0] host_wr_data_w,
  output logic              fab_collision_w
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              past_end, past_end_nxt;
  logic              host_wr, host_rd, fab_wr, seek_oob;
  logic [DATA_W-1:0] ptr_word, fab_word;
  logic              unused_open;

  // The write-side open flag carries no state change for this block.
  assign unused_open = user_w_mem_open_w;

  assign host_wr  = user_w_mem_wren_w & ~past_end;
  assign host_rd  = user_r_mem_rden_w & ~past_end;
  assign seek_oob = {1'b0, user_mem_addr_w} >= DEPTH_X;
  assign fab_wr   = fab_wr_en_w & ({1'b0, fab_addr_w} < DEPTH_X);

  // Seek wins over the increment; simultaneous read+write advance the pointer once.
  always_comb begin
    ptr_nxt      = ptr;
    past_end_nxt = past_end;
    if (user_mem_addr_update_w) begin
      ptr_nxt      = user_mem_addr_w;
      past_end_nxt = 1'b0;
      if (seek_oob) begin
        if (WRAP != 0) ptr_nxt = ADDR_W'({1'b0, user_mem_addr_w} % DEPTH_X);
        else           past_end_nxt = 1'b1;
      end
    end else if (host_wr | host_rd) begin
      if (ptr == LAST) begin
        if (WRAP != 0) ptr_nxt = '0;
        else           past_end_nxt = 1'b1;
      end else begin
        ptr_nxt = ptr + 1'b1;
      end
    end
  end

  // Unmatched addresses (>= DEPTH) fall through to zero.
  always_comb begin
    ptr_word = '0;
    fab_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr == ADDR_W'(i))        ptr_word = mem[i];
      if (fab_addr_w == ADDR_W'(i)) fab_word = mem[i];
    end
  end

  always_ff @(posedge bus_clk_w) begin
    if (!bus_rst_n_w) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr                <= '0;
      past_end           <= 1'b0;
      user_r_mem_data_w  <= '0;
      fab_rd_data_w      <= '0;
      host_wr_valid_w    <= 1'b0;
      host_wr_addr_w     <= '0;
      host_wr_data_w     <= '0;
      fab_collision_w    <= 1'b0;
      user_w_mem_full_w  <= 1'b0;
      user_r_mem_empty_w <= 1'b0;
      user_r_mem_eof_w   <= 1'b0;
    end else begin
      ptr      <= ptr_nxt;
      past_end <= past_end_nxt;
      // Host write takes precedence over a fabric write to the same word.
      for (int i = 0; i < DEPTH; i++) begin
        if (host_wr && ptr == ADDR_W'(i))           mem[i] <= user_w_mem_data_w;
        else if (fab_wr && fab_addr_w == ADDR_W'(i)) mem[i] <= fab_wr_data_w;
      end
      if (host_rd) user_r_mem_data_w <= ptr_word;
      fab_rd_data_w   <= fab_word;
      host_wr_valid_w <= host_wr;
      if (host_wr) begin
        host_wr_addr_w <= ptr;
        host_wr_data_w <= user_w_mem_data_w;
      end
      fab_collision_w    <= host_wr & fab_wr & (fab_addr_w == ptr);
      user_w_mem_full_w  <= past_end_nxt;
      user_r_mem_empty_w <= past_end_nxt;
      user_r_mem_eof_w   <= past_end_nxt & user_r_mem_open_w;
    end
  end

endmodule

// File: tb/tb_xillybus_mem_regfile.sv
// Bench for xillybus_mem_regfile: a WRAP=1/ADDR_W=6 instance driven from a vector table and a WRAP=0 instance
// driven by a hand sequence; host reads and write pulses are matched against queued expectations.
module tb_xillybus_mem_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: WRAP=1, ADDR_W=6, DEPTH=32
  logic [5:0] a_addr, a_faddr, a_hwa;
  logic       a_upd, a_wren, a_wopen, a_full, a_rden, a_ropen, a_empty, a_eof, a_fwen, a_hwv, a_coll;
  logic [7:0] a_wdat, a_rdat, a_fwdat, a_frdat, a_hwd;
  // Instance B: WRAP=0, ADDR_W=5, DEPTH=32
  logic [4:0] b_addr, b_faddr, b_hwa;
  logic       b_upd, b_wren, b_wopen, b_full, b_rden, b_ropen, b_empty, b_eof, b_fwen, b_hwv, b_coll;
  logic [7:0] b_wdat, b_rdat, b_fwdat, b_frdat, b_hwd;

  xillybus_mem_regfile #(.DATA_W(8), .ADDR_W(6), .DEPTH(32), .WRAP(1)) dut_a (
    .bus_clk_w(clk), .bus_rst_n_w(rst_n),
    .user_mem_addr_w(a_addr), .user_mem_addr_update_w(a_upd),
    .user_w_mem_data_w(a_wdat), .user_w_mem_wren_w(a_wren), .user_w_mem_open_w(a_wopen),
    .user_w_mem_full_w(a_full), .user_r_mem_rden_w(a_rden), .user_r_mem_open_w(a_ropen),
    .user_r_mem_data_w(a_rdat), .user_r_mem_empty_w(a_empty), .user_r_mem_eof_w(a_eof),
    .fab_addr_w(a_faddr), .fab_wr_en_w(a_fwen), .fab_wr_data_w(a_fwdat), .fab_rd_data_w(a_frdat),
    .host_wr_valid_w(a_hwv), .host_wr_addr_w(a_hwa), .host_wr_data_w(a_hwd), .fab_collision_w(a_coll)
  );

  xillybus_mem_regfile #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .WRAP(0)) dut_b (
    .bus_clk_w(clk), .bus_rst_n_w(rst_n),
    .user_mem_addr_w(b_addr), .user_mem_addr_update_w(b_upd),
    .user_w_mem_data_w(b_wdat), .user_w_mem_wren_w(b_wren), .user_w_mem_open_w(b_wopen),
    .user_w_mem_full_w(b_full), .user_r_mem_rden_w(b_rden), .user_r_mem_open_w(b_ropen),
    .user_r_mem_data_w(b_rdat), .user_r_mem_empty_w(b_empty), .user_r_mem_eof_w(b_eof),
    .fab_addr_w(b_faddr), .fab_wr_en_w(b_fwen), .fab_wr_data_w(b_fwdat), .fab_rd_data_w(b_frdat),
    .host_wr_valid_w(b_hwv), .host_wr_addr_w(b_hwa), .host_wr_data_w(b_hwd), .fab_collision_w(b_coll)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for instance A
  typedef struct packed { logic [5:0] a; logic [7:0] d; logic c; } wexp_t;
  wexp_t      wq[$];
  logic [7:0] rq[$];
  logic       rd_chk = 1'b0;
  wexp_t      we;

  always @(negedge clk) begin
    if (rd_chk) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_sb: read data %0h with no expectation queued", a_rdat);
      end else chk("host_rd_data", 32'(a_rdat), 32'(rq.pop_front()));
    end
    rd_chk = a_rden & rst_n;
    if (a_hwv) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_sb: unexpected host_wr_valid addr %0h data %0h", a_hwa, a_hwd);
      end else begin
        we = wq.pop_front();
        chk("host_wr_addr", 32'(a_hwa), 32'(we.a));
        chk("host_wr_data", 32'(a_hwd), 32'(we.d));
        chk("fab_collision", 32'(a_coll), 32'(we.c));
      end
    end
  end

  typedef enum logic [2:0] {SEEK, WR, RD, FWR, FRD} op_t;
  typedef struct packed { op_t op; logic [5:0] adr; logic [7:0] dat; logic [7:0] exp; } vec_t;

  function automatic vec_t mk(op_t o, logic [5:0] a, logic [7:0] d, logic [7:0] e);
    mk = '{o, a, d, e};
  endfunction

  // WR: adr is the address the write is expected to land on.
  task automatic apply(input vec_t v);
    case (v.op)
      SEEK: begin a_addr = v.adr; a_upd = 1'b1; cyc(); a_upd = 1'b0; end
      WR: begin
        a_wdat = v.dat; a_wren = 1'b1; wq.push_back('{v.adr, v.dat, 1'b0});
        cyc(); a_wren = 1'b0;
      end
      RD:  begin rq.push_back(v.exp); a_rden = 1'b1; cyc(); a_rden = 1'b0; end
      FWR: begin a_faddr = v.adr; a_fwdat = v.dat; a_fwen = 1'b1; cyc(); a_fwen = 1'b0; end
      default: begin a_faddr = v.adr; cyc(); chk("fab_rd_data", 32'(a_frdat), 32'(v.exp)); end
    endcase
  endtask

  vec_t vt[$];

  initial begin
    rst_n = 1'b0;
    a_addr = '0; a_upd = 0; a_wdat = '0; a_wren = 0; a_wopen = 1; a_rden = 0; a_ropen = 1;
    a_faddr = '0; a_fwen = 0; a_fwdat = '0;
    b_addr = '0; b_upd = 0; b_wdat = '0; b_wren = 0; b_wopen = 1; b_rden = 0; b_ropen = 0;
    b_faddr = '0; b_fwen = 0; b_fwdat = '0;

    vt.push_back(mk(SEEK, 6'd3,  8'h00, 8'h00));
    vt.push_back(mk(WR,   6'd3,  8'hA1, 8'h00));
    vt.push_back(mk(WR,   6'd4,  8'hB2, 8'h00));
    vt.push_back(mk(WR,   6'd5,  8'hC3, 8'h00));
    vt.push_back(mk(FRD,  6'd3,  8'h00, 8'hA1));
    vt.push_back(mk(FRD,  6'd5,  8'h00, 8'hC3));
    vt.push_back(mk(SEEK, 6'd4,  8'h00, 8'h00));
    vt.push_back(mk(RD,   6'd0,  8'h00, 8'hB2));
    vt.push_back(mk(RD,   6'd0,  8'h00, 8'hC3));
    vt.push_back(mk(RD,   6'd0,  8'h00, 8'h00));
    vt.push_back(mk(SEEK, 6'd31, 8'h00, 8'h00));
    vt.push_back(mk(WR,   6'd31, 8'h55, 8'h00));
    vt.push_back(mk(WR,   6'd0,  8'h66, 8'h00));
    vt.push_back(mk(FRD,  6'd31, 8'h00, 8'h55));
    vt.push_back(mk(FRD,  6'd0,  8'h00, 8'h66));
    vt.push_back(mk(SEEK, 6'd40, 8'h00, 8'h00));
    vt.push_back(mk(WR,   6'd8,  8'h77, 8'h00));
    vt.push_back(mk(FRD,  6'd8,  8'h00, 8'h77));
    vt.push_back(mk(FWR,  6'd40, 8'h99, 8'h00));
    vt.push_back(mk(FRD,  6'd8,  8'h00, 8'h77));
    vt.push_back(mk(FRD,  6'd40, 8'h00, 8'h00));
    vt.push_back(mk(FWR,  6'd9,  8'h5A, 8'h00));
    vt.push_back(mk(FRD,  6'd9,  8'h00, 8'h5A));
    vt.push_back(mk(SEEK, 6'd9,  8'h00, 8'h00));
    vt.push_back(mk(RD,   6'd0,  8'h00, 8'h5A));

    cyc(); cyc();
    chk("rst_a_rdat", 32'(a_rdat), 32'd0);
    chk("rst_a_frdat", 32'(a_frdat), 32'd0);
    chk("rst_a_flags", {29'd0, a_full, a_empty, a_eof}, 32'd0);
    chk("rst_a_hwv_coll", {30'd0, a_hwv, a_coll}, 32'd0);
    chk("rst_b_flags", {29'd0, b_full, b_empty, b_eof}, 32'd0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < vt.size(); i++) apply(vt[i]);
    cyc();
    chk("wrap_flags", {29'd0, a_full, a_empty, a_eof}, 32'd0);

    // Simultaneous host write and read: read sees the pre-write word, ptr advances once.
    apply(mk(FWR, 6'd10, 8'h33, 8'h00));
    apply(mk(FWR, 6'd11, 8'h12, 8'h00));
    apply(mk(SEEK, 6'd10, 8'h00, 8'h00));
    a_wdat = 8'h44; a_wren = 1'b1; a_rden = 1'b1;
    rq.push_back(8'h33); wq.push_back('{6'd10, 8'h44, 1'b0});
    cyc(); a_wren = 1'b0; a_rden = 1'b0;
    apply(mk(RD, 6'd0, 8'h00, 8'h12));
    apply(mk(FRD, 6'd10, 8'h00, 8'h44));

    // Host and fabric write the same word in the same cycle.
    apply(mk(SEEK, 6'd7, 8'h00, 8'h00));
    a_faddr = 6'd7; a_fwdat = 8'h22; a_fwen = 1'b1; a_wdat = 8'h11; a_wren = 1'b1;
    wq.push_back('{6'd7, 8'h11, 1'b1});
    cyc(); a_fwen = 1'b0; a_wren = 1'b0;
    cyc();
    chk("coll_one_cycle", 32'(a_coll), 32'd0);
    chk("fab_rd_after_coll", 32'(a_frdat), 32'h11);

    // Host read while fabric writes the same word returns the old word.
    apply(mk(FWR, 6'd12, 8'h21, 8'h00));
    apply(mk(SEEK, 6'd12, 8'h00, 8'h00));
    rq.push_back(8'h21); a_rden = 1'b1;
    a_faddr = 6'd12; a_fwdat = 8'h65; a_fwen = 1'b1;
    cyc(); a_rden = 1'b0; a_fwen = 1'b0;
    apply(mk(FRD, 6'd12, 8'h00, 8'h65));

    // WRAP=0 instance: end-of-range flags, dropped write, seek clears.
    b_addr = 5'd30; b_upd = 1'b1; cyc(); b_upd = 1'b0;
    b_wdat = 8'h10; b_wren = 1'b1; cyc();
    chk("b_hwv_30", {23'd0, b_hwv, b_hwa, b_hwd}, {23'd0, 1'b1, 5'd30, 8'h10});
    chk("b_full_mid", 32'(b_full), 32'd0);
    b_wdat = 8'h20; cyc();
    chk("b_hwv_31", {23'd0, b_hwv, b_hwa, b_hwd}, {23'd0, 1'b1, 5'd31, 8'h20});
    chk("b_full_end", 32'(b_full), 32'd1);
    chk("b_eof_closed", 32'(b_eof), 32'd0);
    b_wdat = 8'h30; cyc(); b_wren = 1'b0;
    chk("b_drop_no_pulse", 32'(b_hwv), 32'd0);
    chk("b_full_hold", 32'(b_full), 32'd1);
    b_ropen = 1'b1; cyc();
    chk("b_empty_eof", {30'd0, b_empty, b_eof}, 32'd3);
    b_faddr = 5'd31; cyc();
    chk("b_mem31", 32'(b_frdat), 32'h20);
    b_faddr = 5'd0; cyc();
    chk("b_mem0_untouched", 32'(b_frdat), 32'h00);
    b_addr = 5'd0; b_upd = 1'b1; cyc(); b_upd = 1'b0;
    chk("b_seek_clears", {29'd0, b_full, b_empty, b_eof}, 32'd0);
    b_addr = 5'd31; b_upd = 1'b1; cyc(); b_upd = 1'b0;
    b_rden = 1'b1; cyc(); b_rden = 1'b0;
    chk("b_rd_last", 32'(b_rdat), 32'h20);
    chk("b_rd_last_empty", 32'(b_empty), 32'd1);
    b_rden = 1'b1; cyc(); b_rden = 1'b0; cyc();
    chk("b_rd_past_end_holds", 32'(b_rdat), 32'h20);

    // Reset lands on the same edge as a host read.
    apply(mk(SEEK, 6'd3, 8'h00, 8'h00));
    a_rden = 1'b1; rst_n = 1'b0;
    cyc(); a_rden = 1'b0; rst_n = 1'b1;
    chk("midrst_rdat", 32'(a_rdat), 32'd0);
    chk("midrst_outs", {29'd0, a_hwv, a_coll, a_full}, 32'd0);
    apply(mk(FRD, 6'd3, 8'h00, 8'h00));
    apply(mk(WR, 6'd0, 8'hE7, 8'h00));
    apply(mk(SEEK, 6'd0, 8'h00, 8'h00));
    apply(mk(RD, 6'd0, 8'h00, 8'hE7));
    cyc(); cyc();

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xillybus_mem_regfile.md
Name: xillybus_mem_regfile

Overview:
- Parametrised user-side successor to the fixed 8-bit/5-bit-address seekable mem stream attached to the xillybus core.
- Implements an addressable register file of DEPTH words, DATA_W bits each, behind the core's seekable mem_* stream pair: write stream, read stream, address and address-update.
- Adds a second fabric-side port for hardware access, selectable wrap or end-of-file address mode, and host-write notification to the fabric.

Parameters:
- DATA_W, 8, word width of the host streams and the fabric port (8, 16 or 32).
- ADDR_W, 5, width of the host seek address and the fabric address.
- DEPTH, 32, number of implemented words; must satisfy 2 <= DEPTH <= 2**ADDR_W and DEPTH <= 64.
- WRAP, 1, end-of-range mode: 1 = pointer wraps DEPTH-1 -> 0; 0 = end-of-file/full at end of range.

Ports:
- bus_clk_w  in  1  sole clock.
- bus_rst_n_w  in  1  synchronous reset, active low.
- user_mem_addr_w  in  ADDR_W  seek address from the core.
- user_mem_addr_update_w  in  1  seek strobe.
- user_w_mem_data_w  in  DATA_W  host write data.
- user_w_mem_wren_w  in  1  host write strobe.
- user_w_mem_open_w  in  1  write stream open (informational).
- user_w_mem_full_w  out  1  host write backpressure.
- user_r_mem_rden_w  in  1  host read strobe.
- user_r_mem_open_w  in  1  read stream open.
- user_r_mem_data_w  out  DATA_W  host read data.
- user_r_mem_empty_w  out  1  read empty.
- user_r_mem_eof_w  out  1  read end-of-file.
- fab_addr_w  in  ADDR_W  fabric address.
- fab_wr_en_w  in  1  fabric write strobe.
- fab_wr_data_w  in  DATA_W  fabric write data.
- fab_rd_data_w  out  DATA_W  fabric read data.
- host_wr_valid_w  out  1  one-cycle pulse per accepted host write.
- host_wr_addr_w  out  ADDR_W  address of that write.
- host_wr_data_w  out  DATA_W  data of that write.
- fab_collision_w  out  1  pulse when a fabric write loses arbitration.

Behaviour:
- Reset (bus_rst_n_w low at a rising edge):
  - All DEPTH words cleared to 0; ptr = 0; past_end = 0.
  - All outputs 0.
  - Reset mid-operation discards any in-flight strobe; outputs are at reset values from the next edge.
- Seek: user_mem_addr_update_w loads ptr <= user_mem_addr_w and clears past_end.
  - If the loaded address is >= DEPTH: with WRAP=1, ptr <= address mod DEPTH; with WRAP=0, past_end <= 1.
  - Seek has priority over any increment in the same cycle.
- Host write: accepted when wren=1 and past_end=0.
  - mem[ptr] <= data; ptr advances.
  - Next cycle: host_wr_valid=1 for exactly one cycle, carrying the address and data written.
  - Writes while past_end=1 are dropped silently, with no pulse.
- Host read: accepted when rden=1 and past_end=0.
  - user_r_mem_data_w <= mem[ptr] at the edge, so data is valid the cycle after rden (1-cycle latency); ptr advances.
  - Data is held until the next accepted read.
- Simultaneous wren and rden: both use the same ptr value; the read returns the pre-write word; ptr advances once.
- Pointer advance at ptr == DEPTH-1: WRAP=1 gives ptr <= 0; WRAP=0 holds ptr and sets past_end <= 1.
- Flag outputs, all registered:
  - user_r_mem_empty_w = past_end.
  - user_r_mem_eof_w = past_end & user_r_mem_open_w.
  - user_w_mem_full_w = past_end.
  - With WRAP=1 all three stay 0 for the whole run.
- Open/close events do not modify ptr or memory.
- Fabric port:
  - fab_rd_data_w <= mem[fab_addr_w] each cycle (1-cycle latency, read-before-write).
  - fab_wr_en writes mem[fab_addr_w]; addresses >= DEPTH are ignored on both read and write (read returns 0).
- Collision: an accepted host write and a fabric write to the same address in the same cycle.
  - Host data is stored.
  - fab_collision_w pulses for one cycle, aligned with host_wr_valid.
- Host read and fabric write to the same address in the same cycle: the host read returns the old word.

Test Plan:
- Reset, seek 3, write A1,B2,C3 (DATA_W=8) -> mem[3..5]=A1,B2,C3; host_wr_valid pulses three times with addr 3,4,5; full stays 0.
- Seek 4, three rden pulses -> data B2, C3, 00, each valid the cycle after its rden; empty and eof stay 0.
- WRAP=0, DEPTH=32: seek 30, write 3 words -> words 30 and 31 stored; full=1 after the second write; third write dropped; open read shows empty=1, eof=1; seek 0 clears all flags.
- WRAP=1: seek 31, write 55 then 66 -> mem[31]=55, mem[0]=66, no flags; seek 40 with DEPTH=32, ADDR_W=6 -> ptr=8.
- Same cycle: host write 0x11 and fabric write 0x22 to address 7 -> mem[7]=0x11; fab_collision=1 for one cycle; fab_rd_data at address 7 shows 0x11 two cycles later.
- Assert reset for one cycle between a rden and its data cycle -> data output 0, ptr=0, memory cleared; next seek/read works normally.
